// File: rtl/tdnn_pkg.sv
// ============================================================================
// tdnn_pkg : shared widths and state encoding for the TDNN input front end
// Rev 1.0
// ============================================================================
`default_nettype none

package tdnn_pkg;

  localparam int c_SIG_SIZE = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2
  } cond_state_t;

endpackage

`default_nettype wire

// File: rtl/vec_debounce.sv
// ============================================================================
// vec_debounce : two-flop synchroniser plus whole-vector debouncer
// Rev 1.0
// ============================================================================
`default_nettype none

module vec_debounce
  import tdnn_pkg::*;
#(
  parameter int SIG_SIZE        = c_SIG_SIZE,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SIG_SIZE-1:0] i_sw,
  output logic [SIG_SIZE-1:0] o_stable,
  output logic                o_commit
);

  localparam int               c_CW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_CW-1:0]  c_CNT_MAX = c_CW'(DEBOUNCE_CYCLES - 1);

  logic [SIG_SIZE-1:0] r_s1;
  logic [SIG_SIZE-1:0] r_s2;
  logic [SIG_SIZE-1:0] r_cand;
  logic [c_CW-1:0]     r_cnt;
  logic [SIG_SIZE-1:0] r_stable;
  logic                r_commit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1     <= '0;
      r_s2     <= '0;
      r_cand   <= '0;
      r_cnt    <= '0;
      r_stable <= '0;
      r_commit <= 1'b0;
    end else begin
      r_s1     <= i_sw;
      r_s2     <= r_s1;
      r_commit <= 1'b0;
      // Any bit change restarts the count for the whole vector.
      if (r_s2 != r_cand) begin
        r_cand <= r_s2;
        r_cnt  <= '0;
      end else if (r_cnt == c_CNT_MAX) begin
        r_stable <= r_cand;
        r_commit <= 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_stable = r_stable;
  assign o_commit = r_commit;

endmodule

`default_nettype wire

// File: rtl/sig_in_conditioner.sv
// ============================================================================
// sig_in_conditioner : debounced, periodically sampled switch word for TDNN core
// Rev 1.0
// ============================================================================
`default_nettype none

module sig_in_conditioner
  import tdnn_pkg::*;
#(
  parameter int SIG_SIZE        = c_SIG_SIZE,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SAMPLE_DIV      = 100_000
) (
  input  logic                topclk,
  input  logic                reset,
  input  logic [SIG_SIZE-1:0] sw,
  output logic [SIG_SIZE-1:0] sig_out,
  output logic                sig_valid,
  output logic                sig_changed,
  output logic                wb_en
);

  localparam int              c_DW      = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [c_DW-1:0] c_DIV_MAX = c_DW'(SAMPLE_DIV - 1);

  logic [SIG_SIZE-1:0] w_stable;
  logic                w_commit;
  logic                w_tick;
  logic [c_DW-1:0]     r_div;
  cond_state_t         r_state;
  logic [SIG_SIZE-1:0] r_sig_out;
  logic                r_sig_valid;
  logic                r_sig_changed;
  logic                r_wb_en;

  vec_debounce #(
    .SIG_SIZE        (SIG_SIZE),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (topclk),
    .rst      (reset),
    .i_sw     (sw),
    .o_stable (w_stable),
    .o_commit (w_commit)
  );

  // Free-running in every state so the sample phase is fixed from reset.
  always_ff @(posedge topclk) begin
    if (reset) begin
      r_div <= '0;
    end else if (r_div == c_DIV_MAX) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  assign w_tick = (r_div == c_DIV_MAX);

  always_ff @(posedge topclk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_wb_en       <= 1'b0;
      r_sig_out     <= '0;
      r_sig_valid   <= 1'b0;
      r_sig_changed <= 1'b0;
    end else begin
      r_sig_valid   <= 1'b0;
      r_sig_changed <= 1'b0;
      case (r_state)
        IDLE: begin
          r_state <= SETTLE;
          r_wb_en <= 1'b0;
        end
        SETTLE: begin
          if (w_commit) begin
            r_state <= RUN;
            r_wb_en <= 1'b1;
          end
        end
        RUN: begin
          r_wb_en <= 1'b1;
          // A commit on this same edge is seen at the following tick.
          if (w_tick) begin
            r_sig_out     <= w_stable;
            r_sig_valid   <= 1'b1;
            r_sig_changed <= (w_stable != r_sig_out);
          end
        end
        default: begin
          r_state <= IDLE;
          r_wb_en <= 1'b0;
        end
      endcase
    end
  end

  assign sig_out     = r_sig_out;
  assign sig_valid   = r_sig_valid;
  assign sig_changed = r_sig_changed;
  assign wb_en       = r_wb_en;

endmodule

`default_nettype wire

// File: doc/sig_in_conditioner.md
# sig_in_conditioner

Input front end for the TDNN board top: takes the 16 raw slide-switch levels, synchronises them to `topclk`, debounces them as one vector, and presents a clean, periodically sampled signal word with a one-cycle valid strobe. It also produces the weight-bus enable, which goes high only once the first debounced word exists. Its outputs feed the TDNN core inputs `SIG_IN1`/`SIG_IN2` and the core's `wb_en` directly.

## Interface
- `SIG_SIZE`, 16, width of the switch and signal words.
- `DEBOUNCE_CYCLES`, 1_000_000, consecutive unchanged cycles required before a new switch vector is committed (≥2).
- `SAMPLE_DIV`, 100_000, sample period in `topclk` cycles (≥2).
- `topclk`  input  1  system clock; all logic on its rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `sw`  input  SIG_SIZE  raw asynchronous switch levels.
- `sig_out`  output  SIG_SIZE  sampled, debounced signal word.
- `sig_valid`  output  1  one-cycle pulse when `sig_out` takes a new sample.
- `sig_changed`  output  1  one-cycle pulse, coincident with `sig_valid`, when the new sample differs from the previous `sig_out`.
- `wb_en`  output  1  weight-bus enable to the TDNN core; high in RUN only.

## Operation
- Synchroniser: two flops per bit, `s1` then `s2`, both reset to 0.
- Debouncer: `cand` (SIG_SIZE), `cnt` (clog2(DEBOUNCE_CYCLES) bits), `stable` (SIG_SIZE), all reset to 0.
  - `s2 != cand`: `cand <= s2`, `cnt <= 0`.
  - `s2 == cand` and `cnt == DEBOUNCE_CYCLES-1`: `stable <= cand`, `commit` pulses for one cycle, and `cnt` holds. Commits repeat while `cnt` holds; this is harmless.
  - Otherwise: `cnt <= cnt + 1`.
  - Any bit toggling restarts the whole-vector count. Per-bit independence is not required.
- Sample divider: `div` counts from 0 to SAMPLE_DIV-1 and wraps. It resets to 0 and runs in every state. `tick` is `div == SAMPLE_DIV-1`.
- FSM, resetting to IDLE:
  - IDLE → SETTLE unconditionally on the next cycle.
  - SETTLE → RUN on the first `commit`.
  - RUN stays in RUN until reset.
- Sampling: `tick` in RUN registers `sig_out <= stable`, `sig_valid <= 1`, and `sig_changed <= (stable != sig_out)`. All three update on the same edge. `tick` outside RUN does nothing.
- `wb_en` is registered and equals 1 in every cycle the FSM is in RUN.
- Reset values: `sig_out` = 0, `sig_valid` = 0, `sig_changed` = 0, `wb_en` = 0.
- Reset mid-operation: all state returns to reset values on the next edge. Any in-progress debounce or sample is discarded, and `wb_en` drops.

## Timing
- Switch change that stays stable: `s2` updates at edge +2, `cand` at edge +3, and `stable` commits at edge +3+DEBOUNCE_CYCLES.
- Commit to `wb_en` (first commit while in SETTLE): `wb_en` rises at edge +1 after the commit.
- `stable` to `sig_out`: 1 to SAMPLE_DIV cycles, depending on divider phase.
- `sig_valid` is high for exactly one cycle every SAMPLE_DIV cycles in RUN and is never high outside RUN.
- Simultaneous commit and tick: `sig_out` takes the pre-commit `stable`. The new value appears at the following tick.
- Bounce shorter than DEBOUNCE_CYCLES is never committed, whatever its duty cycle.

## Structure
- Shared package `tdnn_pkg`: the `SIG_SIZE` default and the typedef `cond_state_t` enum {IDLE, SETTLE, RUN}.
- One sub-module, `vec_debounce`, containing the synchroniser, debouncer and `commit` output. The top contains the divider, FSM and output registers.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and SAMPLE_DIV=8.
- Reset release with `sw`=0 → first commit at edge 4 after reset release; `wb_en`=1 at edge 5; `sig_valid` fires at the next `div`=7 edge with `sig_out`=0x0000 and `sig_changed`=0.
- `sw`=0xA5A5 held in RUN → `stable`=0xA5A5 at +7; next tick gives `sig_out`=0xA5A5, `sig_valid`=1, `sig_changed`=1; the tick after gives `sig_changed`=0.
- Bit 0 toggling every 3 cycles for 40 cycles → no commit; `sig_out` unchanged and `sig_changed`=0 on every tick.
- `sw` changes so that the commit lands on a `div`=7 edge → that tick outputs the old word, and the next tick outputs the new word with `sig_changed`=1.
- `reset` asserted for one cycle in RUN with `sig_out`=0x1234 → next edge gives `sig_out`=0, `wb_en`=0, `sig_valid`=0; the SETTLE sequence repeats.
- `sw` changed during SETTLE before the first commit → `wb_en` stays 0 until 4 stable cycles after the last change.
